// File: rtl/sprite_dispatcher.sv
// Sprite descriptor dispatcher: buffers descriptors, fetches texture row pairs and broadcasts them to the stream processors.
// Optional WAIT timeout with sticky mem_err is enabled by defining SPRITE_DISPATCH_TIMEOUT_EN.
module sprite_dispatcher #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TEX_ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_start,
   input  logic                  desc_valid,
   output logic                  desc_ready,
   input  logic [TEX_ADDR_W-1:0] desc_tex_addr,
   input  logic [3:0]            desc_start_x,
   input  logic [7:0]            desc_z,
   input  logic                  desc_last,
   output logic                  mem_req,
   output logic [TEX_ADDR_W-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [255:0]          mem_rdata,
   output logic                  o_ena,
   output logic [255:0]          o_texture_data,
   output logic [3:0]            o_start_x,
   output logic [7:0]            o_position_z,
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
   output logic                  mem_err,
`endif
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned DATA_W = 256;
   localparam int unsigned X_W    = 4;
   localparam int unsigned Z_W    = 8;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
   localparam int unsigned TMO_W     = 4;
   localparam int unsigned TMO_LIMIT = 14;
`endif

   typedef struct packed {
      logic [TEX_ADDR_W-1:0] tex_addr;
      logic [X_W-1:0]        start_x;
      logic [Z_W-1:0]        z;
      logic                  last;
   } desc_t;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_ISSUE, S_DONE
   } state_e;

   state_e state_q, state_d;

   desc_t            fifo_mem [FIFO_DEPTH];
   desc_t            desc_in, head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             push, pop, fifo_empty;

   logic [X_W-1:0]        cur_x_q, cur_x_d;
   logic [Z_W-1:0]        cur_z_q, cur_z_d;
   logic                  cur_last_q, cur_last_d;
   logic [TEX_ADDR_W-1:0] addr_q, addr_d;
   logic                  req_q, req_d;
   logic                  ena_q, ena_d;
   logic [DATA_W-1:0]     tex_q, tex_d;
   logic [X_W-1:0]        x_q, x_d;
   logic [Z_W-1:0]        z_q, z_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  err_q, err_d;
`endif

   // Descriptor FIFO bookkeeping; ready is registered from the next occupancy.
   always_comb begin
      desc_in    = {desc_tex_addr, desc_start_x, desc_z, desc_last};
      head       = fifo_mem[rd_ptr_q];
      fifo_empty = (cnt_q == '0);
      push       = desc_valid && ready_q;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
      ready_d    = (cnt_d != CNT_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= desc_in;
      end
   end

   // Next-state and output logic; outputs are registered from the state being entered.
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      cur_x_d    = cur_x_q;
      cur_z_d    = cur_z_q;
      cur_last_d = cur_last_q;
      addr_d     = addr_q;
      ena_d      = 1'b0;
      tex_d      = tex_q;
      x_d        = x_q;
      z_d        = z_q;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
      tmo_d      = tmo_q;
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_CLEAR;
               ena_d   = 1'b1;
               tex_d   = '0;
               x_d     = '0;
               z_d     = '0;
            end
         end
         S_CLEAR: state_d = S_FETCH;
         S_FETCH: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head.z == '0) begin
                  state_d = head.last ? S_DONE : S_FETCH;
               end else begin
                  cur_x_d    = head.start_x;
                  cur_z_d    = head.z;
                  cur_last_d = head.last;
                  addr_d     = head.tex_addr;
                  state_d    = S_WAIT;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
                  tmo_d      = '0;
`endif
               end
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               state_d = S_ISSUE;
               ena_d   = 1'b1;
               tex_d   = mem_rdata;
               x_d     = cur_x_q;
               z_d     = cur_z_q;
            end
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TMO_LIMIT)) begin
               err_d   = 1'b1;
               state_d = cur_last_q ? S_DONE : S_FETCH;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
`endif
         end
         S_ISSUE: state_d = cur_last_q ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      req_d  = (state_d == S_WAIT);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         cur_x_q    <= '0;
         cur_z_q    <= '0;
         cur_last_q <= 1'b0;
         addr_q     <= '0;
         req_q      <= 1'b0;
         ena_q      <= 1'b0;
         tex_q      <= '0;
         x_q        <= '0;
         z_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
         tmo_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         cur_x_q    <= cur_x_d;
         cur_z_q    <= cur_z_d;
         cur_last_q <= cur_last_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         ena_q      <= ena_d;
         tex_q      <= tex_d;
         x_q        <= x_d;
         z_q        <= z_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
         tmo_q      <= tmo_d;
         err_q      <= err_d;
`endif
      end
   end

   assign desc_ready     = ready_q;
   assign mem_req        = req_q;
   assign mem_addr       = addr_q;
   assign o_ena          = ena_q;
   assign o_texture_data = tex_q;
   assign o_start_x      = x_q;
   assign o_position_z   = z_q;
   assign busy           = busy_q;
   assign frame_done     = done_q;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
   assign mem_err        = err_q;
`endif

endmodule

// File: tb/tb_sprite_dispatcher.sv
// Self-checking bench for sprite_dispatcher: transaction-level model of frames, fetches and broadcasts,
// plus directed literal checks of the key scenarios.
module tb_sprite_dispatcher;

   logic         clk;
   logic         reset_n;
   logic         frame_start;
   logic         desc_valid;
   logic         desc_ready;
   logic [7:0]   desc_tex_addr;
   logic [3:0]   desc_start_x;
   logic [7:0]   desc_z;
   logic         desc_last;
   logic         mem_req;
   logic [7:0]   mem_addr;
   logic         mem_ack;
   logic [255:0] mem_rdata;
   logic         o_ena;
   logic [255:0] o_texture_data;
   logic [3:0]   o_start_x;
   logic [7:0]   o_position_z;
   logic         busy;
   logic         frame_done;
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
   logic         mem_err;
`endif

   sprite_dispatcher #(.FIFO_DEPTH(4), .TEX_ADDR_W(8)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .frame_start    (frame_start),
      .desc_valid     (desc_valid),
      .desc_ready     (desc_ready),
      .desc_tex_addr  (desc_tex_addr),
      .desc_start_x   (desc_start_x),
      .desc_z         (desc_z),
      .desc_last      (desc_last),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .o_ena          (o_ena),
      .o_texture_data (o_texture_data),
      .o_start_x      (o_start_x),
      .o_position_z   (o_position_z),
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
      .mem_err        (mem_err),
`endif
      .busy           (busy),
      .frame_done     (frame_done)
   );

   typedef struct {
      logic [7:0] addr;
      logic [3:0] x;
      logic [7:0] z;
      logic       last;
   } mdesc_t;

   int     tests = 0;
   int     fails = 0;
   mdesc_t mq[$];
   bit     clear_pending = 0, done_pending = 0, in_frame = 0;
   bit     req_prev = 0, ack_prev = 0;
   int     cyc = 0, ack_cyc = -10;
   int     n_req = 0, n_issue = 0, n_done = 0;
   logic [7:0] held_addr = '0;
   bit     resp_en = 1, stray_ack = 0;
   int     ack_delay = 0;

   // Texture memory contents: every byte of a row pair is the address xor 0xBB.
   function automatic logic [255:0] tex_of(input logic [7:0] a);
      return {32{a ^ 8'hBB}};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Texture memory responder, acting just after each rising edge.
   initial begin
      int wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (reset_n && resp_en && mem_req && !mem_ack) begin
            if (wcnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = tex_of(mem_addr);
            end else begin
               wcnt++;
            end
         end else begin
            mem_ack = stray_ack;
            if (stray_ack) mem_rdata = '1;
            wcnt = 0;
         end
      end
   end

   // Reference model and per-cycle compare.
   always @(negedge clk) begin
      mdesc_t d;
      cyc++;
      if (reset_n) begin
         if (o_ena) begin
            if (clear_pending) begin
               chk("clear_data", o_texture_data, '0);
               chk("clear_x", 256'(o_start_x), '0);
               chk("clear_z", 256'(o_position_z), '0);
               clear_pending = 0;
            end else if (mq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ena: got o_ena=1, required 0");
            end else begin
               d = mq.pop_front();
               chk("issue_data", o_texture_data, tex_of(d.addr));
               chk("issue_x", 256'(o_start_x), 256'(d.x));
               chk("issue_z", 256'(o_position_z), 256'(d.z));
               chk("issue_timing", 256'(cyc), 256'(ack_cyc + 1));
               n_issue++;
               if (d.last) done_pending = 1;
            end
         end
         if (mem_req && !req_prev) begin
            while (mq.size() > 0 && mq[0].z == 8'd0 && !mq[0].last) void'(mq.pop_front());
            if (mq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_req: got mem_req=1 addr %0h, required 0", mem_addr);
            end else begin
               chk("req_addr", 256'(mem_addr), 256'(mq[0].addr));
            end
            n_req++;
            held_addr = mem_addr;
         end else if (mem_req) begin
            chk("addr_stable", 256'(mem_addr), 256'(held_addr));
         end
         if (ack_prev) begin
            chk("req_drop_after_ack", 256'(mem_req), '0);
         end else if (req_prev && !mem_req && mq.size() > 0) begin
            d = mq.pop_front();
            if (d.last) done_pending = 1;
         end
         if (frame_done) begin
            if (!done_pending) begin
               while (mq.size() > 0 && mq[0].z == 8'd0) begin
                  d = mq.pop_front();
                  if (d.last) begin
                     done_pending = 1;
                     break;
                  end
               end
            end
            chk("frame_done_due", 256'(done_pending), 256'(1));
            done_pending = 0;
            in_frame = 0;
            n_done++;
         end
         if (mem_ack && mem_req) ack_cyc = cyc;
      end
      req_prev = reset_n && mem_req;
      ack_prev = reset_n && mem_ack && mem_req;
   end

   task automatic start_frame();
      bit exp_clear;
      exp_clear = !in_frame;
      if (exp_clear) begin
         clear_pending = 1;
         in_frame = 1;
      end
      frame_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      frame_start = 1'b0;
      chk(exp_clear ? "clear_pulse" : "no_second_clear", 256'(o_ena), 256'(exp_clear));
   endtask

   task automatic push_desc(input logic [7:0] a, input logic [3:0] x, input logic [7:0] z, input logic l);
      logic acc;
      desc_valid    = 1'b1;
      desc_tex_addr = a;
      desc_start_x  = x;
      desc_z        = z;
      desc_last     = l;
      for (int n = 0; n < 300; n++) begin
         acc = desc_ready;
         @(posedge clk);
         if (acc) break;
         @(negedge clk);
         #1;
      end
      if (acc) mq.push_back('{addr: a, x: x, z: z, last: l});
      else begin
         tests++;
         fails++;
         $display("FAIL push_timeout: got desc_ready=0, required 1");
      end
      @(negedge clk);
      #1;
      desc_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!frame_done && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("frame_done_seen", 256'(frame_done), 256'(1));
   endtask

   task automatic wait_req(input int budget);
      int n;
      n = 0;
      while (!mem_req && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("mem_req_seen", 256'(mem_req), 256'(1));
   endtask

   initial begin
      logic [255:0] lit_ab;
      int r, i, dn, hi;
      lit_ab        = {32{8'hAB}};
      reset_n       = 1'b1;
      frame_start   = 1'b0;
      desc_valid    = 1'b0;
      desc_tex_addr = '0;
      desc_start_x  = '0;
      desc_z        = '0;
      desc_last     = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_busy", 256'(busy), '0);
      chk("rst_ena", 256'(o_ena), '0);
      chk("rst_req", 256'(mem_req), '0);
      chk("rst_done", 256'(frame_done), '0);
      chk("rst_ready", 256'(desc_ready), '0);
      chk("rst_data", o_texture_data, '0);
`ifdef SPRITE_DISPATCH_TIMEOUT_EN
      chk("rst_err", 256'(mem_err), '0);
`endif
      @(negedge clk);
      @(negedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("ready_after_reset", 256'(desc_ready), 256'(1));

      // Single sprite frame
      ack_delay = 2;
      start_frame();
      push_desc(8'h10, 4'd3, 8'd5, 1'b1);
      wait_done(100);
      chk("lit_data", o_texture_data, lit_ab);
      chk("lit_x", 256'(o_start_x), 256'(3));
      chk("lit_z", 256'(o_position_z), 256'(5));
      chk("busy_in_done", 256'(busy), 256'(1));
      chk("frames_1", 256'(n_done), 256'(1));
      @(negedge clk);
      #1;
      chk("idle_after_done", 256'(busy), '0);
      chk("done_one_cycle", 256'(frame_done), '0);
      chk("data_held", o_texture_data, lit_ab);

      // Zero-depth last descriptor is dropped without a fetch
      r = n_req;
      i = n_issue;
      start_frame();
      push_desc(8'h22, 4'd1, 8'd0, 1'b1);
      wait_done(100);
      chk("zero_no_req", 256'(n_req), 256'(r));
      chk("zero_no_issue", 256'(n_issue), 256'(i));
      chk("frames_2", 256'(n_done), 256'(2));
      @(negedge clk);
      #1;

      // FIFO back-pressure: four fill it while idle, fifth waits for the first pop
      ack_delay = 1;
      i = n_issue;
      for (int k = 0; k < 4; k++) push_desc(8'(8'h31 + k), 4'(k + 1), 8'(10 + k), 1'b0);
      chk("full_ready_low", 256'(desc_ready), '0);
      chk("idle_with_data", 256'(busy), '0);
      fork
         push_desc(8'h35, 4'd5, 8'd14, 1'b1);
         start_frame();
         begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("ready_low_in_clear", 256'(desc_ready), '0);
         end
      join
      wait_done(300);
      chk("five_issued", 256'(n_issue), 256'(i + 5));
      chk("frames_3", 256'(n_done), 256'(3));
      @(negedge clk);
      #1;

      // Stray acknowledge while idle must do nothing
      i = n_issue;
      stray_ack = 1;
      repeat (3) @(negedge clk);
      #1;
      stray_ack = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("stray_no_issue", 256'(n_issue), 256'(i));
      chk("stray_idle", 256'(busy), '0);

      // frame_start during WAIT is ignored
      ack_delay = 8;
      dn = n_done;
      start_frame();
      push_desc(8'h40, 4'd7, 8'd9, 1'b1);
      wait_req(50);
      start_frame();
      wait_done(100);
      chk("one_frame", 256'(n_done), 256'(dn + 1));
      repeat (6) @(negedge clk);
      #1;
      chk("no_extra_frame", 256'(n_done), 256'(dn + 1));
      chk("idle_after_restart", 256'(busy), '0);

      // Asynchronous reset in WAIT abandons the read and empties the FIFO
      resp_en = 0;
      start_frame();
      push_desc(8'h50, 4'd2, 8'd3, 1'b1);
      wait_req(50);
      #1 reset_n = 1'b0;
      mq.delete();
      clear_pending = 0;
      done_pending  = 0;
      in_frame      = 0;
      #1;
      chk("rst_wait_req", 256'(mem_req), '0);
      chk("rst_wait_busy", 256'(busy), '0);
      chk("rst_wait_ena", 256'(o_ena), '0);
      chk("rst_wait_ready", 256'(desc_ready), '0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      resp_en = 1;
      ack_delay = 0;
      @(negedge clk);
      #1;
      chk("ready_after_rst2", 256'(desc_ready), 256'(1));
      start_frame();
      push_desc(8'h60, 4'd9, 8'h7F, 1'b1);
      wait_done(100);
      chk("post_rst_x", 256'(o_start_x), 256'(9));
      chk("post_rst_z", 256'(o_position_z), 256'(8'h7F));
      chk("post_rst_data", o_texture_data, {32{8'hDB}});
      @(negedge clk);
      #1;

`ifdef SPRITE_DISPATCH_TIMEOUT_EN
      // Unanswered read times out after 15 WAIT cycles
      resp_en = 0;
      i = n_issue;
      push_desc(8'h70, 4'd1, 8'd2, 1'b0);
      push_desc(8'h71, 4'd3, 8'd4, 1'b1);
      start_frame();
      wait_req(20);
      hi = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (!mem_req) break;
         hi++;
      end
      resp_en = 1;
      chk("tmo_cycles", 256'(hi), 256'(15));
      chk("tmo_err", 256'(mem_err), 256'(1));
      wait_done(100);
      chk("tmo_next_issued", 256'(n_issue), 256'(i + 1));
      chk("tmo_next_x", 256'(o_start_x), 256'(3));
      chk("tmo_err_sticky", 256'(mem_err), 256'(1));
      @(negedge clk);
      #1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

endmodule
